// File: rtl/dmem_bus_if_pkg.sv
// Shared core definitions: bus FSM state encoding,
// common constants and the pipeline stall vector width.
package mips_defines;

    localparam int          StallW   = 6;
    localparam logic [31:0] ZeroWord = 32'h0000_0000;

    typedef enum logic [1:0] {
        IDLE       = 2'b00,
        BUSY       = 2'b01,
        WAIT_STALL = 2'b10
    } bus_state_e;

endpackage

// File: rtl/dmem_bus_if_if.sv
// Wishbone B4 classic signal bundle between the data-side
// bus interface (master) and the RAM / fabric (slave).
interface dmem_bus_if_if;

    logic [31:0] wb_adr_o;
    logic [31:0] wb_dat_o;
    logic [31:0] wb_dat_i;
    logic        wb_we_o;
    logic [3:0]  wb_sel_o;
    logic        wb_stb_o;
    logic        wb_cyc_o;
    logic        wb_ack_i;

    modport master (
        output wb_adr_o, wb_dat_o, wb_we_o, wb_sel_o,
        output wb_stb_o, wb_cyc_o,
        input  wb_dat_i, wb_ack_i
    );

    modport slave (
        input  wb_adr_o, wb_dat_o, wb_we_o, wb_sel_o,
        input  wb_stb_o, wb_cyc_o,
        output wb_dat_i, wb_ack_i
    );

endinterface

// File: rtl/dmem_bus_if_watchdog.sv
// Bus watchdog: 8-bit cycle counter flagging the last
// allowed wait cycle of a bus transfer.
module bus_watchdog #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    localparam logic [7:0] Last = 8'(TIMEOUT - 1);

    logic [7:0] cnt_q, cnt_d;

    // Clear has priority over counting.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = 8'd0;
        end else if (en_i) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= 8'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = (cnt_q == Last);

endmodule

// File: rtl/dmem_bus_if.sv
// Data-side bus interface: turns MEM-stage requests into
// registered Wishbone classic cycles with stall/flush/timeout.
module dmem_bus_if
    import mips_defines::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [StallW-1:0] stall_i,
    input  logic              flush_i,
    input  logic              cpu_ce_i,
    input  logic              cpu_we_i,
    input  logic [31:0]       cpu_addr_i,
    input  logic [3:0]        cpu_sel_i,
    input  logic [31:0]       cpu_data_i,
    output logic [31:0]       cpu_data_o,
    output logic              stallreq_o,
    output logic              err_o,
    dmem_bus_if_if.master     wb
);

    bus_state_e  state_q, state_d;
    logic [31:0] adr_q, adr_d;
    logic [31:0] dat_q, dat_d;
    logic [3:0]  sel_q, sel_d;
    logic        we_q, we_d;
    logic        cyc_q, cyc_d;
    logic        err_q, err_d;
    logic [31:0] rbuf_q, rbuf_d;
    logic        wd_clr, wd_en, expired;

    bus_watchdog #(.TIMEOUT(TIMEOUT)) u_wd (
        .clk       (clk),
        .rst       (rst),
        .clr_i     (wd_clr),
        .en_i      (wd_en),
        .expired_o (expired)
    );

    // Next-state and bus register update.
    always_comb begin
        state_d = state_q;
        adr_d   = adr_q;
        dat_d   = dat_q;
        sel_d   = sel_q;
        we_d    = we_q;
        cyc_d   = cyc_q;
        err_d   = 1'b0;
        rbuf_d  = rbuf_q;
        wd_clr  = 1'b0;
        wd_en   = 1'b0;
        case (state_q)
            IDLE: begin
                if (cpu_ce_i && !flush_i) begin
                    adr_d   = cpu_addr_i;
                    dat_d   = cpu_data_i;
                    sel_d   = cpu_sel_i;
                    we_d    = cpu_we_i;
                    cyc_d   = 1'b1;
                    wd_clr  = 1'b1;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (flush_i || wb.wb_ack_i || expired) begin
                    adr_d   = ZeroWord;
                    dat_d   = ZeroWord;
                    sel_d   = 4'h0;
                    we_d    = 1'b0;
                    cyc_d   = 1'b0;
                    state_d = IDLE;
                    if (!flush_i && wb.wb_ack_i) begin
                        if (!we_q) begin
                            rbuf_d = wb.wb_dat_i;
                        end
                        if (stall_i != '0) begin
                            state_d = WAIT_STALL;
                        end
                    end else if (!flush_i) begin
                        err_d = 1'b1;
                    end
                end else begin
                    wd_en = 1'b1;
                end
            end
            WAIT_STALL: begin
                if (stall_i == '0) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, bus and read-buffer registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            adr_q   <= ZeroWord;
            dat_q   <= ZeroWord;
            sel_q   <= 4'h0;
            we_q    <= 1'b0;
            cyc_q   <= 1'b0;
            err_q   <= 1'b0;
            rbuf_q  <= ZeroWord;
        end else begin
            state_q <= state_d;
            adr_q   <= adr_d;
            dat_q   <= dat_d;
            sel_q   <= sel_d;
            we_q    <= we_d;
            cyc_q   <= cyc_d;
            err_q   <= err_d;
            rbuf_q  <= rbuf_d;
        end
    end

    // Stall request and load data toward the MEM stage.
    always_comb begin
        stallreq_o = 1'b0;
        cpu_data_o = ZeroWord;
        case (state_q)
            IDLE: begin
                stallreq_o = cpu_ce_i & ~flush_i;
            end
            BUSY: begin
                stallreq_o = ~wb.wb_ack_i & ~flush_i & ~expired;
                if (wb.wb_ack_i && !flush_i && !we_q) begin
                    cpu_data_o = wb.wb_dat_i;
                end
            end
            WAIT_STALL: begin
                cpu_data_o = rbuf_q;
            end
            default: ;
        endcase
    end

    assign err_o       = err_q;
    assign wb.wb_adr_o = adr_q;
    assign wb.wb_dat_o = dat_q;
    assign wb.wb_sel_o = sel_q;
    assign wb.wb_we_o  = we_q;
    assign wb.wb_stb_o = cyc_q;
    assign wb.wb_cyc_o = cyc_q;

endmodule
